// File: rtl/tl_ul_arb2.sv
// Two-to-one TileLink-UL arbiter: round-robin A grant locked across Put bursts, D routed by source MSB.
// Optional macro TL_ARB2_INFLIGHT_LIMIT_EN caps outstanding A messages per requester at MAX_INFLIGHT.
module tl_ul_arb2 #(
    parameter int MAX_SIZE     = 6,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a0_valid,
    output logic                a0_ready,
    input  logic [81:0]         a0_bits,
    input  logic                a1_valid,
    output logic                a1_ready,
    input  logic [81:0]         a1_bits,
    output logic                ma_valid,
    input  logic                ma_ready,
    output logic [82:0]         ma_bits,
    output logic                d0_valid,
    input  logic                d0_ready,
    output logic [45:0]         d0_bits,
    output logic                d1_valid,
    input  logic                d1_ready,
    output logic [45:0]         d1_bits,
    input  logic                md_valid,
    output logic                md_ready,
    input  logic [46:0]         md_bits,
    output logic                o_dbg_state,
    output logic [MAX_SIZE-2:0] o_dbg_beat_cnt,
    output logic                o_dbg_rr_ptr,
    output logic                o_dbg_lock_id
);
    localparam int BCW = MAX_SIZE - 1;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // valid never depends on ready, and every valid/ready output is held low during reset.

    // Oversized requests are clamped so an illegal size can lock at most one maximum burst.
    function automatic logic [BCW-1:0] beats_f(input logic burst_op, input logic [3:0] size);
        logic [3:0] s;
        s = (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
        if (burst_op && (s > 4'd2))
            beats_f = BCW'(1) << (s - 4'd2);
        else
            beats_f = BCW'(1);
    endfunction

    state_t         r_state, w_state_nxt;
    logic           r_rr_ptr, w_rr_nxt;
    logic           r_lock_id, w_lock_nxt;
    logic [BCW-1:0] r_beat_cnt, w_cnt_nxt;

    logic           w_elig0, w_elig1;
    logic           w_grant, w_gvalid;
    logic [81:0]    w_a_bits;
    logic [BCW-1:0] w_a_beats;
    logic           w_a_fire, w_a_last;
    logic           w_d_sel, w_d_fire;

    always_comb begin
        w_grant  = r_rr_ptr;
        w_gvalid = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_elig0 && w_elig1) begin
                w_grant  = r_rr_ptr;
                w_gvalid = 1'b1;
            end else if (w_elig0) begin
                w_grant  = 1'b0;
                w_gvalid = 1'b1;
            end else if (w_elig1) begin
                w_grant  = 1'b1;
                w_gvalid = 1'b1;
            end
        end else begin
            w_grant  = r_lock_id;
            w_gvalid = r_lock_id ? a1_valid : a0_valid;
        end
    end

    assign w_a_bits  = w_grant ? a1_bits : a0_bits;
    assign ma_valid  = w_gvalid & ~reset;
    assign ma_bits   = {w_a_bits[81:72], w_grant, w_a_bits[71:0]};
    assign a0_ready  = ~reset & w_gvalid & ~w_grant & ma_ready;
    assign a1_ready  = ~reset & w_gvalid & w_grant & ma_ready;
    assign w_a_fire  = ma_valid & ma_ready;
    assign w_a_beats = beats_f((w_a_bits[81:79] == 3'd0) || (w_a_bits[81:79] == 3'd1), w_a_bits[75:72]);
    assign w_a_last  = (r_state == S_IDLE) ? (w_a_beats == BCW'(1)) : (r_beat_cnt <= BCW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock_id;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_a_fire) begin
                    if (w_a_last) begin
                        w_rr_nxt = ~w_grant;
                    end else begin
                        w_state_nxt = S_BURST;
                        w_lock_nxt  = w_grant;
                        w_cnt_nxt   = w_a_beats - BCW'(1);
                    end
                end
            end
            S_BURST: begin
                if (w_a_fire) begin
                    w_cnt_nxt = r_beat_cnt - BCW'(1);
                    if (w_a_last) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = ~r_lock_id;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_lock_id  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_id  <= w_lock_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    assign o_dbg_state    = r_state;
    assign o_dbg_beat_cnt = r_beat_cnt;
    assign o_dbg_rr_ptr   = r_rr_ptr;
    assign o_dbg_lock_id  = r_lock_id;

    // D routing is per beat: the source MSB names the requester, so no lock is needed.
    assign w_d_sel  = md_bits[37];
    assign d0_valid = ~reset & md_valid & ~w_d_sel;
    assign d1_valid = ~reset & md_valid & w_d_sel;
    assign d0_bits  = {md_bits[46:38], md_bits[36:0]};
    assign d1_bits  = {md_bits[46:38], md_bits[36:0]};
    assign md_ready = ~reset & (w_d_sel ? d1_ready : d0_ready);
    assign w_d_fire = md_valid & md_ready;

`ifdef TL_ARB2_INFLIGHT_LIMIT_EN
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);

    logic [IFW-1:0] r_inflight0, r_inflight1;
    logic [BCW-1:0] r_d_rem0, r_d_rem1;
    logic [BCW-1:0] w_d_beats;
    logic           w_inc0, w_inc1, w_dec0, w_dec1;

    assign w_elig0   = a0_valid & (r_inflight0 < IFW'(MAX_INFLIGHT));
    assign w_elig1   = a1_valid & (r_inflight1 < IFW'(MAX_INFLIGHT));
    assign w_d_beats = beats_f(md_bits[46:44] == 3'd1, md_bits[41:38]);
    assign w_inc0    = w_a_fire & ~w_grant & w_a_last;
    assign w_inc1    = w_a_fire & w_grant & w_a_last;
    // A remaining count of zero means the next beat on that port starts a new response.
    assign w_dec0    = w_d_fire & ~w_d_sel &
                       ((r_d_rem0 == '0) ? (w_d_beats == BCW'(1)) : (r_d_rem0 == BCW'(1)));
    assign w_dec1    = w_d_fire & w_d_sel &
                       ((r_d_rem1 == '0) ? (w_d_beats == BCW'(1)) : (r_d_rem1 == BCW'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight0 <= '0;
            r_inflight1 <= '0;
            r_d_rem0    <= '0;
            r_d_rem1    <= '0;
        end else begin
            if (w_d_fire && !w_d_sel)
                r_d_rem0 <= (r_d_rem0 == '0) ? (w_d_beats - BCW'(1)) : (r_d_rem0 - BCW'(1));
            if (w_d_fire && w_d_sel)
                r_d_rem1 <= (r_d_rem1 == '0) ? (w_d_beats - BCW'(1)) : (r_d_rem1 - BCW'(1));
            if (w_inc0 && !w_dec0)
                r_inflight0 <= r_inflight0 + IFW'(1);
            else if (w_dec0 && !w_inc0 && (r_inflight0 != '0))
                r_inflight0 <= r_inflight0 - IFW'(1);
            if (w_inc1 && !w_dec1)
                r_inflight1 <= r_inflight1 + IFW'(1);
            else if (w_dec1 && !w_inc1 && (r_inflight1 != '0))
                r_inflight1 <= r_inflight1 - IFW'(1);
        end
    end
`else
    assign w_elig0 = a0_valid;
    assign w_elig1 = a1_valid;
`endif

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: round-robin table, burst lock with stall, reset mid-burst, D routing,
// and the inflight limit when TL_ARB2_INFLIGHT_LIMIT_EN is defined.
module tb_tl_ul_arb2;
    logic        clock;
    logic        reset;
    logic        a0_valid, a0_ready, a1_valid, a1_ready;
    logic [81:0] a0_bits, a1_bits;
    logic        ma_valid, ma_ready;
    logic [82:0] ma_bits;
    logic        d0_valid, d0_ready, d1_valid, d1_ready;
    logic [45:0] d0_bits, d1_bits;
    logic        md_valid, md_ready;
    logic [46:0] md_bits;
    logic        dbg_state, dbg_rr_ptr, dbg_lock_id;
    logic [4:0]  dbg_beat_cnt;

    tl_ul_arb2 dut (
        .clock(clock), .reset(reset),
        .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_bits(a0_bits),
        .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_bits(a1_bits),
        .ma_valid(ma_valid), .ma_ready(ma_ready), .ma_bits(ma_bits),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_bits(d0_bits),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_bits(d1_bits),
        .md_valid(md_valid), .md_ready(md_ready), .md_bits(md_bits),
        .o_dbg_state(dbg_state), .o_dbg_beat_cnt(dbg_beat_cnt),
        .o_dbg_rr_ptr(dbg_rr_ptr), .o_dbg_lock_id(dbg_lock_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [82:0] exp_a_q[$];
    logic [46:0] exp_d_q[$];

    logic [2:0]  opc_r[2];
    logic [3:0]  sz_r[2];
    logic [3:0]  src_r[2];
    logic [31:0] adr_r[2];
    logic [31:0] dat_r[2];

    typedef struct {
        logic v0, v1, mr;
        logic e_mv, e_g, e_r0, e_r1;
    } rr_vec_t;
    rr_vec_t vecs[12];

    function automatic rr_vec_t rv(input logic v0, input logic v1, input logic mr,
                                   input logic e_mv, input logic e_g, input logic e_r0, input logic e_r1);
        rr_vec_t t;
        t.v0 = v0; t.v1 = v1; t.mr = mr;
        t.e_mv = e_mv; t.e_g = e_g; t.e_r0 = e_r0; t.e_r1 = e_r1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [82:0] act, input logic [82:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int r, input logic v, input logic [2:0] opc, input logic [3:0] sz);
        logic [81:0] b;
        opc_r[r] = opc;
        sz_r[r]  = sz;
        src_r[r] = 4'($urandom_range(0, 15));
        adr_r[r] = $urandom;
        dat_r[r] = $urandom;
        b = {opc, 3'd0, sz, src_r[r], adr_r[r], 4'hF, dat_r[r]};
        if (r == 0) begin a0_valid = v; a0_bits = b; end
        else        begin a1_valid = v; a1_bits = b; end
    endtask

    function automatic logic [82:0] exp_a(input int r);
        return {opc_r[r], 3'd0, sz_r[r], (r == 1), src_r[r], adr_r[r], 4'hF, dat_r[r]};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // A scoreboard: every accepted downstream beat must match the oldest expected beat.
    always @(negedge clock) begin
        if (!reset && ma_valid === 1'b1 && ma_ready === 1'b1) begin
            n_vec++;
            if (exp_a_q.size() == 0) begin
                n_err++;
                $display("FAIL a_sb: got unexpected beat %h, expected none", ma_bits);
            end else begin
                logic [82:0] e;
                e = exp_a_q.pop_front();
                if (ma_bits !== e) begin
                    n_err++;
                    $display("FAIL a_sb: got %h, expected %h", ma_bits, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && ((d0_valid === 1'b1 && d0_ready === 1'b1) || (d1_valid === 1'b1 && d1_ready === 1'b1))) begin
            logic [46:0] got;
            got = (d1_valid === 1'b1) ? {1'b1, d1_bits} : {1'b0, d0_bits};
            n_vec++;
            if (exp_d_q.size() == 0) begin
                n_err++;
                $display("FAIL d_sb: got unexpected beat %h, expected none", got);
            end else begin
                logic [46:0] e;
                e = exp_d_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL d_sb: got %h, expected %h", got, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] dd;
        reset = 1'b1;
        a0_valid = 1'b1; a1_valid = 1'b1; a0_bits = '0; a1_bits = '0;
        ma_ready = 1'b1; d0_ready = 1'b1; d1_ready = 1'b1;
        md_valid = 1'b1; md_bits = {3'd0, 2'd0, 4'd2, 5'h10, 1'b0, 32'h0};

        vecs[0]  = rv(1, 1, 1, 1, 0, 1, 0);
        vecs[1]  = rv(1, 1, 1, 1, 1, 0, 1);
        vecs[2]  = rv(1, 1, 1, 1, 0, 1, 0);
        vecs[3]  = rv(1, 1, 1, 1, 1, 0, 1);
        vecs[4]  = rv(0, 1, 1, 1, 1, 0, 1);
        vecs[5]  = rv(0, 1, 1, 1, 1, 0, 1);
        vecs[6]  = rv(1, 1, 0, 1, 0, 0, 0);
        vecs[7]  = rv(1, 0, 1, 1, 0, 1, 0);
        vecs[8]  = rv(1, 0, 1, 1, 0, 1, 0);
        vecs[9]  = rv(0, 0, 1, 0, 0, 0, 0);
        vecs[10] = rv(1, 1, 1, 1, 1, 0, 1);
        vecs[11] = rv(1, 1, 1, 1, 0, 1, 0);

        // Reset: every valid/ready output held low even with all inputs active.
        @(negedge clock);
        chk("rst_outputs", {ma_valid, a0_ready, a1_ready, d0_valid, d1_valid, md_ready}, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_regs", {dbg_state, dbg_rr_ptr, dbg_lock_id, dbg_beat_cnt}, 0);
        a0_valid = 1'b0; a1_valid = 1'b0; md_valid = 1'b0;
        do_reset();

        // Round-robin table with single-beat Gets.
        for (int i = 0; i < 12; i++) begin
            set_a(0, vecs[i].v0, 3'd4, 4'd2);
            set_a(1, vecs[i].v1, 3'd4, 4'd2);
            ma_ready = vecs[i].mr;
            if (vecs[i].e_mv && vecs[i].mr) exp_a_q.push_back(exp_a(vecs[i].e_g ? 1 : 0));
            @(negedge clock);
            chk($sformatf("rr_hs[%0d]", i), {ma_valid, a0_ready, a1_ready}, {vecs[i].e_mv, vecs[i].e_r0, vecs[i].e_r1});
            if (vecs[i].e_mv) chk($sformatf("rr_grant[%0d]", i), ma_bits[72], vecs[i].e_g);
            tick();
        end
        a0_valid = 1'b0; a1_valid = 1'b0; ma_ready = 1'b1;

        // 4-beat PutFull from a0 locks out a1; a 10-cycle stall before beat 3.
        do_reset();
        set_a(1, 1'b1, 3'd4, 4'd2);
        for (int k = 0; k < 4; k++) begin
            set_a(0, 1'b1, 3'd0, 4'd4);
            if (k == 2) begin
                ma_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clock);
                    chk("stall_bits", ma_bits, exp_a(0));
                    chk("stall_cnt", {dbg_state, dbg_beat_cnt}, {1'b1, 5'd2});
                    chk("stall_rdy", {ma_valid, a0_ready, a1_ready}, 3'b100);
                    tick();
                end
                ma_ready = 1'b1;
            end
            exp_a_q.push_back(exp_a(0));
            @(negedge clock);
            chk($sformatf("burst_hs[%0d]", k), {ma_valid, a0_ready, a1_ready, ma_bits[72]}, 4'b1100);
            tick();
        end
        a0_valid = 1'b0;
        exp_a_q.push_back(exp_a(1));
        @(negedge clock);
        chk("after_burst", {ma_valid, a0_ready, a1_ready, ma_bits[72], dbg_state}, 5'b10110);
        tick();
        a1_valid = 1'b0;

        // Reset after beat 2 of an 8-beat Put from a1.
        do_reset();
        a0_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_a(1, 1'b1, 3'd0, 4'd5);
            exp_a_q.push_back(exp_a(1));
            @(negedge clock);
            chk($sformatf("pre_rst_hs[%0d]", k), {ma_valid, a1_ready, ma_bits[72]}, 3'b111);
            tick();
        end
        chk("pre_rst_cnt", {dbg_state, dbg_lock_id, dbg_beat_cnt}, {1'b1, 1'b1, 5'd6});
        reset = 1'b1;
        set_a(0, 1'b1, 3'd4, 4'd2);
        md_valid = 1'b1; md_bits = {3'd1, 2'd0, 4'd3, 5'h12, 1'b0, 32'h1234};
        @(negedge clock);
        chk("rst_mid_outputs", {ma_valid, a0_ready, a1_ready, d0_valid, d1_valid, md_ready}, 0);
        tick();
        reset = 1'b0; md_valid = 1'b0;
        exp_a_q.push_back(exp_a(0));
        @(negedge clock);
        chk("post_rst_state", {dbg_state, dbg_beat_cnt}, 0);
        chk("post_rst_grant", {ma_valid, a0_ready, a1_ready, ma_bits[72]}, 4'b1100);
        tick();
        a0_valid = 1'b0; a1_valid = 1'b0;

        // D: 2-beat AccessAckData to source 5'h13 with d1_ready toggling.
        d0_ready = 1'b1;
        dd = $urandom;
        md_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) dd = $urandom;
            md_bits = {3'd1, 2'd0, 4'd3, 5'h13, 1'b0, dd};
            d1_ready = c[0];
            if (c[0]) exp_d_q.push_back({1'b1, 3'd1, 2'd0, 4'd3, 4'h3, 1'b0, dd});
            @(negedge clock);
            chk($sformatf("d1_route[%0d]", c), {d0_valid, d1_valid, md_ready, d1_bits[36:33]}, {1'b0, 1'b1, c[0], 4'h3});
            tick();
        end
        // AccessAck to requester 0: stalled once by d0_ready, then accepted.
        dd = $urandom;
        md_bits = {3'd0, 2'd0, 4'd2, 5'h05, 1'b1, dd};
        d1_ready = 1'b1;
        d0_ready = 1'b0;
        @(negedge clock);
        chk("d0_stall", {d0_valid, d1_valid, md_ready}, 3'b100);
        tick();
        d0_ready = 1'b1;
        exp_d_q.push_back({1'b0, 3'd0, 2'd0, 4'd2, 4'h5, 1'b1, dd});
        @(negedge clock);
        chk("d0_route", {d0_valid, d1_valid, md_ready}, 3'b101);
        tick();
        md_valid = 1'b0;

`ifdef TL_ARB2_INFLIGHT_LIMIT_EN
        // Inflight limit: 4 Gets from a0 exhaust its credit until one AccessAck returns.
        do_reset();
        a1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_a(0, 1'b1, 3'd4, 4'd2);
            exp_a_q.push_back(exp_a(0));
            @(negedge clock);
            chk($sformatf("inf_fill[%0d]", k), {ma_valid, a0_ready, ma_bits[72]}, 3'b110);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            set_a(0, 1'b1, 3'd4, 4'd2);
            set_a(1, 1'b1, 3'd4, 4'd2);
            exp_a_q.push_back(exp_a(1));
            if (k == 1) begin
                dd = $urandom;
                md_valid = 1'b1; d0_ready = 1'b1;
                md_bits = {3'd0, 2'd0, 4'd2, 5'h00, 1'b0, dd};
                exp_d_q.push_back({1'b0, 3'd0, 2'd0, 4'd2, 4'h0, 1'b0, dd});
            end
            @(negedge clock);
            chk($sformatf("inf_block[%0d]", k), {ma_valid, a0_ready, a1_ready, ma_bits[72]}, 4'b1011);
            tick();
        end
        md_valid = 1'b0;
        set_a(0, 1'b1, 3'd4, 4'd2);
        set_a(1, 1'b1, 3'd4, 4'd2);
        exp_a_q.push_back(exp_a(0));
        @(negedge clock);
        chk("inf_release", {ma_valid, a0_ready, a1_ready, ma_bits[72]}, 4'b1100);
        tick();
        a0_valid = 1'b0; a1_valid = 1'b0;
`endif

        @(negedge clock);
        chk("a_q_empty", 83'(exp_a_q.size()), 0);
        chk("d_q_empty", 83'(exp_d_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-to-one TileLink-UL arbiter placed in front of a rational-crossing sink, so two masters share one crossing.
- A-channel: round-robin grant, locked for the full duration of multi-beat Put bursts. The requester index is prepended to the A source.
- D-channel: responses are routed back to the requester named by the source MSB, and that MSB is stripped.

Parameters:
- MAX_SIZE, 6, largest legal log2 transfer size (bytes). Maximum burst is 2^(MAX_SIZE-2) beats of 32 bits.
- MAX_INFLIGHT, 4, outstanding A messages allowed per requester. Used only with TL_ARB2_INFLIGHT_LIMIT_EN.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- a0_valid  in  1  requester 0 A valid.
- a0_ready  out  1  requester 0 A ready.
- a0_bits  in  82  {opcode[81:79], param[78:76], size[75:72], source[71:68], address[67:36], mask[35:32], data[31:0]}.
- a1_valid / a1_ready / a1_bits  in / out / in  1 / 1 / 82  requester 1 A channel, same packing as requester 0.
- ma_valid  out  1  downstream A valid.
- ma_ready  in  1  downstream A ready.
- ma_bits  out  83  a*_bits with source widened to 5 bits: source[4] = requester index.
- d0_valid  out  1  requester 0 D valid.
- d0_ready  in  1  requester 0 D ready.
- d0_bits  out  46  {opcode[45:43], param[42:41], size[40:37], source[36:33], denied[32], data[31:0]}.
- d1_valid / d1_ready / d1_bits  out / in / out  1 / 1 / 46  requester 1 D channel, same packing as requester 0.
- md_valid  in  1  downstream D valid.
- md_ready  out  1  downstream D ready.
- md_bits  in  47  as d*_bits with a 5-bit source.

Behaviour:
- Beat count per message:
  - A-channel: beats = (opcode is PutFull 0 or PutPartial 1) and size > 2 ? 2^(size-2) : 1.
  - D-channel: beats = (opcode is AccessAckData 1) and size > 2 ? 2^(size-2) : 1.
  - size > MAX_SIZE is illegal input; behaviour is undefined, but it must not deadlock beyond one burst of 2^(MAX_SIZE-2) beats.
- A state machine, IDLE / BURST:
  - IDLE, eligible requester selection: both eligible → grant the requester that rr_ptr points to; one eligible → grant it; none → ma_valid = 0.
  - IDLE, combinational path: ma_valid, ma_bits and the granted a*_ready follow the granted requester in the same cycle. The ungranted ready is 0. Zero added latency.
  - IDLE, single-beat handshake: stay in IDLE; rr_ptr = the other requester.
  - IDLE, first beat of a multi-beat handshake: go to BURST, latch lock_id = granted requester, beat_cnt = beats-1.
  - BURST: only lock_id is connected. The other requester's ready is 0 even if its valid is high. Each handshake decrements beat_cnt.
  - BURST last beat (beat_cnt == 1 at handshake): go to IDLE; rr_ptr = the other requester. The next grant is computed in the following cycle.
- The locked requester dropping valid mid-burst keeps the lock; there is no timeout.
- Source handling:
  - ma_bits.source = {grant, a.source}.
  - D routing: md_bits.source[4] selects d0 or d1. md_ready = the selected d*_ready. The unselected d*_valid is 0. d*_bits.source = md source[3:0].
  - D routing is per beat and purely combinational; D bursts need no lock because the source identifies the requester.
- Reset:
  - Values: state = IDLE, rr_ptr = 0, beat_cnt = 0, lock_id = 0.
  - While reset is high, ma_valid, a0_ready, a1_ready, d0_valid, d1_valid and md_ready are all forced to 0.
  - Reset mid-burst abandons the burst; after reset the next grant is arbitrated fresh.
- Eligible = a*_valid, AND (with the optional feature) inflight < MAX_INFLIGHT.

Optional Feature:
- Macro: TL_ARB2_INFLIGHT_LIMIT_EN.
- Defined, counters:
  - Per-requester inflight counters, width clog2(MAX_INFLIGHT+1), reset to 0.
  - +1 on the last A beat of that requester; -1 on the last D beat routed to it. Per-port D beat counters are added for this.
  - Simultaneous +1 and -1 leave the counter unchanged.
- Defined, effects on arbitration:
  - A requester at MAX_INFLIGHT is ineligible in IDLE; its a*_ready is 0.
  - A burst already locked always completes.
- Not defined: no counters; eligible = a*_valid only.

Test Plan:
- Both a0/a1 valid with Get size 2, ma_ready = 1 constant → grants alternate 0,1,0,1; ma_bits.source[4] alternates; first grant is requester 0 after reset.
- a0 PutFull size 4 (4 beats) and a1 valid throughout → 4 consecutive requester-0 beats, a1_ready = 0 during them, then the a1 beat.
- md AccessAckData size 3 with source 5'h13, d1_ready toggling → 2 beats on d1 with source 4'h3, d0_valid = 0, md_ready mirrors d1_ready.
- Reset asserted after beat 2 of an 8-beat Put from a1 → all valid/ready outputs 0 during reset; afterwards state is IDLE and a0 is granted first.
- With TL_ARB2_INFLIGHT_LIMIT_EN and MAX_INFLIGHT = 4: 4 Gets from a0 with no D → a0_ready = 0 while a1 is still granted; one AccessAck to source 5'h00 → a0 eligible again the next cycle.
- ma_ready = 0 for 10 cycles mid-burst → ma_bits is stable and beat_cnt is unchanged; the burst resumes without losing beats.
